// File: rtl/token_embedder.sv
// Token embedder: reads token IDs, fetches each token's embedding row and streams its elements out.
// Optional macro TOKEN_EMBEDDER_ZERO_TERM_EN: a token ID of 0 ends the run early.
module token_embedder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int EMB_DIM    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_WIDTH:0]                   tok_count,
    output logic                                  busy,
    output logic                                  done,
    output logic [ADDR_WIDTH-1:0]                 tok_addr,
    input  logic [DATA_WIDTH-1:0]                 tok_data,
    output logic [ADDR_WIDTH+$clog2(EMB_DIM)-1:0] emb_addr,
    input  logic [DATA_WIDTH-1:0]                 emb_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_last,
    output logic                                  out_tok_last
);

    localparam int EW = $clog2(EMB_DIM);
    localparam logic [EW-1:0]         ELEM_MAX = EW'(EMB_DIM - 1);
    localparam logic [EW-1:0]         ELEM_ONE = EW'(1);
    localparam logic [ADDR_WIDTH-1:0] TOK_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH + 1)'(0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TOK_RD   = 3'd1,
        S_TOK_WAIT = 3'd2,
        S_EMB_RD   = 3'd3,
        S_EMB_WAIT = 3'd4,
        S_OUT      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   tok_idx_r;
    logic [EW-1:0]           elem_idx_r;
    logic [DATA_WIDTH-1:0]   tok_id_r;
    logic [ADDR_WIDTH:0]     cnt_r;
    logic                    last_elem_s;
    logic                    last_tok_s;
    logic                    tok_id_unused_s;

    assign last_elem_s = (elem_idx_r == ELEM_MAX);
    // cnt_r is never 0 outside IDLE/DONE, so the subtraction cannot underflow where it matters
    assign last_tok_s  = ({1'b0, tok_idx_r} == (cnt_r - CNT_ONE));

    assign tok_addr = tok_idx_r;
    assign emb_addr = {tok_id_r[ADDR_WIDTH-1:0], elem_idx_r};

    // Upper token-ID bits select nothing in the vocabulary-sized embedding table
    assign tok_id_unused_s = ^tok_id_r[DATA_WIDTH-1:ADDR_WIDTH];

    // Sequencer: token fetch, embedding fetch and output handshake, with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            tok_idx_r    <= '0;
            elem_idx_r   <= '0;
            tok_id_r     <= '0;
            cnt_r        <= '0;
            out_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_tok_last <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cnt_r      <= tok_count;
                        tok_idx_r  <= '0;
                        elem_idx_r <= '0;
                        busy       <= 1'b1;
                        if (tok_count == CNT_ZERO) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= S_TOK_RD;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_TOK_RD: begin
                    state_r <= S_TOK_WAIT;
                end
                S_TOK_WAIT: begin
                    tok_id_r <= tok_data;
`ifdef TOKEN_EMBEDDER_ZERO_TERM_EN
                    // ID 0 is the encoder's end-of-word marker
                    if (tok_data == {DATA_WIDTH{1'b0}}) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        state_r <= S_EMB_RD;
                    end
`else
                    state_r <= S_EMB_RD;
`endif
                end
                S_EMB_RD: begin
                    state_r <= S_EMB_WAIT;
                end
                S_EMB_WAIT: begin
                    out_data     <= emb_data;
                    out_last     <= last_elem_s;
                    out_tok_last <= last_tok_s;
                    out_valid    <= 1'b1;
                    state_r      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!last_elem_s) begin
                            elem_idx_r <= elem_idx_r + ELEM_ONE;
                            state_r    <= S_EMB_RD;
                        end else if (!last_tok_s) begin
                            elem_idx_r <= '0;
                            tok_idx_r  <= tok_idx_r + TOK_ONE;
                            state_r    <= S_TOK_RD;
                        end else begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_r <= S_OUT;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r   <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/token_embedder.md
Name: token_embedder

Overview:
- Downstream of the encoder stage; consumes the token-ID stream the encoder writes into its output SRAM.
- For each token ID, fetches the token's EMB_DIM-element embedding vector from an embedding SRAM.
- Streams the vector elements, one per handshake, to the tensor-core input over a valid/ready interface.
- Both SRAMs are the codebase's synchronous sram: read data is valid one cycle after the address is presented.

Parameters:
- ADDR_WIDTH, 4, token-RAM address width; the vocabulary holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, width of a token ID and of one embedding element.
- EMB_DIM, 4, elements per embedding vector; must be a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- tok_count  in  ADDR_WIDTH+1  number of tokens to process; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- tok_addr  out  ADDR_WIDTH  token-RAM read address.
- tok_data  in  DATA_WIDTH  token-RAM read data.
- emb_addr  out  ADDR_WIDTH+log2(EMB_DIM)  embedding-RAM read address.
- emb_data  in  DATA_WIDTH  embedding-RAM read data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  embedding element.
- out_last  out  1  current element is the last of its vector.
- out_tok_last  out  1  current element belongs to the last token of the run.

Behaviour:
- Reset (async, any state): state=IDLE; tok_idx, elem_idx, tok_id, out_data and cnt all 0; busy, done, out_valid, out_last, out_tok_last all 0.
- Addressing:
  - tok_addr = tok_idx[ADDR_WIDTH-1:0].
  - emb_addr = {tok_id[ADDR_WIDTH-1:0], elem_idx}; upper tok_id bits are ignored.
  - Addresses are driven from registers and are stable for the whole read cycle.
- IDLE:
  - On start, latch cnt=tok_count and clear tok_idx and elem_idx.
  - If tok_count==0, go to DONE; otherwise go to TOK_RD.
- TOK_RD: present tok_addr; go to TOK_WAIT.
- TOK_WAIT: tok_data is valid; latch tok_id=tok_data; go to EMB_RD.
- EMB_RD: present emb_addr; go to EMB_WAIT.
- EMB_WAIT: emb_data is valid; register it into out_data; set out_last and out_tok_last; go to OUT.
- OUT:
  - out_valid=1; out_data, out_last and out_tok_last are held stable until out_valid && out_ready.
  - On handshake, if elem_idx<EMB_DIM-1: elem_idx++, go to EMB_RD.
  - Else if tok_idx<cnt-1: elem_idx=0, tok_idx++, go to TOK_RD.
  - Else go to DONE.
  - out_valid deasserts the cycle after the handshake.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Latency: start sampled at edge T gives out_valid high after edge T+4. Each subsequent element arrives 2 cycles after the previous handshake; a new token costs 4 cycles.
- Boundary conditions:
  - start while busy is ignored.
  - tok_count is ignored after it is latched.
  - tok_count=2**ADDR_WIDTH is legal; tok_idx wraps to 0 only after the final token.
  - out_ready high before out_valid has no effect.
  - rst mid-run aborts immediately: no done pulse, out_valid drops asynchronously.
  - start held high across DONE→IDLE starts a new run on the IDLE cycle.

Optional Feature:
- Macro: TOKEN_EMBEDDER_ZERO_TERM_EN.
- Defined: in TOK_WAIT, a tok_data of 0 (the encoder's end-of-word marker) ends the run early.
  - Go directly to DONE; no elements are emitted for that token.
  - out_tok_last is therefore known only for the tok_count-th token.
  - If token 0 is the first token read, no output is produced and done still pulses.
- Undefined: token ID 0 is an ordinary vocabulary index; its row at emb_addr 0..EMB_DIM-1 is emitted.

Test Plan:
- Basic run, tok_count=2, token RAM {3,5}, emb[k]=k, out_ready tied 1 → out_data sequence 12,13,14,15,20,21,22,23; out_last on 15 and 23; out_tok_last on 20..23; first out_valid 4 cycles after start; one done pulse.
- Backpressure: same setup with out_ready low for 3 cycles while out_valid=1 → out_data, out_last and out_tok_last unchanged throughout; no element lost or duplicated.
- tok_count=0 → no out_valid; done pulses 1 cycle after start; busy high for exactly 1 cycle.
- Reset mid-vector: assert rst while emitting element 2 of token 1 → out_valid and busy are 0 immediately and done never pulses; a new start with tok_count=1 replays from token-RAM address 0.
- start pulsed during OUT → ignored; run completes with the original tok_count; back-to-back start held high → second run begins on the IDLE cycle after done.
- With TOKEN_EMBEDDER_ZERO_TERM_EN, token RAM {7,0,4}, tok_count=3 → only emb rows 28..31 are emitted, then done; without the macro, rows 28..31, 0..3 and 16..19 are emitted.
